// File: rtl/control_circuit_if.sv
// ---------------------------------------------------------------------------
// control_circuit_if
//   Bundles the instruction input and every datapath strobe of the control
//   FSM so the controller and whatever sources instructions share one port.
//
//   Signals:
//     INSTRUCTION   [10:0] opcode[10:8], Rx[7:5], Ry[4:2] (load: [4:0] payload)
//     Rin           [3:0]  register load enables, bit0=r1 .. bit3=r4
//     Rout          [3:0]  register bus-drive enables, same mapping
//     ALU_a_in             load ALU operand register A from the bus
//     ALU_g_in             load ALU result register G
//     ALU_g_out            G drives the bus
//     Done                 final cycle of the current instruction
//     External_data        external data drives the bus
//     ALU_mode             0 = add, 1 = subtract
//
//   Modports:
//     master - instruction source / observer (drives INSTRUCTION)
//     slave  - the controller (drives all strobes)
// ---------------------------------------------------------------------------
interface control_circuit_if;
  logic [10:0] INSTRUCTION;
  logic [3:0]  Rin;
  logic [3:0]  Rout;
  logic        ALU_a_in;
  logic        ALU_g_in;
  logic        ALU_g_out;
  logic        Done;
  logic        External_data;
  logic        ALU_mode;

  modport master (
    output INSTRUCTION,
    input  Rin, Rout, ALU_a_in, ALU_g_in, ALU_g_out, Done, External_data,
           ALU_mode
  );

  modport slave (
    input  INSTRUCTION,
    output Rin, Rout, ALU_a_in, ALU_g_in, ALU_g_out, Done, External_data,
           ALU_mode
  );
endinterface

// File: rtl/control_circuit.sv
// ---------------------------------------------------------------------------
// control_circuit
//   Control FSM for a 4-register multi-cycle processor with one shared bus.
//   Latches an instruction in T0 and sequences register/ALU/external-data
//   strobes through T1..T3, raising Done on the last cycle.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     bus        control_circuit_if.slave (INSTRUCTION in, strobes out)
//     state_dbg  [1:0]  current state (only with CONTROL_STATE_DEBUG_EN)
//     ir_dbg     [10:0] latched instruction (only with CONTROL_STATE_DEBUG_EN)
//
//   Optional feature macro: CONTROL_STATE_DEBUG_EN adds the two debug ports.
//
//   Instruction acceptance: there is no valid/ready pair. The controller is
//   "ready" exactly while in T0 and samples INSTRUCTION on every rising edge
//   there, so the source must present a valid instruction whenever the
//   controller is in T0; Done marks the final cycle, after which T0 follows.
//   INSTRUCTION is ignored in T1..T3.
// ---------------------------------------------------------------------------
module control_circuit (
  input  logic                 clk,
  input  logic                 reset,
  control_circuit_if.slave     bus
`ifdef CONTROL_STATE_DEBUG_EN
  ,
  output logic [1:0]           state_dbg,
  output logic [10:0]          ir_dbg
`endif
);

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;

  state_t      state_q, state_d;
  logic [10:0] ir_q;

  logic [2:0]  opcode;
  logic [3:0]  rx_sel, ry_sel;
  logic        is_alu_op;

  logic [3:0]  rin, rout;
  logic        a_in, g_in, g_out, done, ext_data, alu_mode;

  // Field code 001..100 selects r1..r4; every other code selects nothing.
  function automatic logic [3:0] reg_decode(input logic [2:0] code);
    logic [3:0] sel;
    case (code)
      3'b001:  sel = 4'b0001;
      3'b010:  sel = 4'b0010;
      3'b011:  sel = 4'b0100;
      3'b100:  sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  assign opcode    = ir_q[10:8];
  assign rx_sel    = reg_decode(ir_q[7:5]);
  assign ry_sel    = reg_decode(ir_q[4:2]);
  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T0) begin
        ir_q <= bus.INSTRUCTION;
      end
    end
  end

  // Outputs depend only on state and the latched IR. Since reset forces
  // state to T0, and T0 drives nothing, outputs drop to 0 as soon as reset
  // is asserted.
  always_comb begin
    state_d  = T0;
    rin      = 4'b0000;
    rout     = 4'b0000;
    a_in     = 1'b0;
    g_in     = 1'b0;
    g_out    = 1'b0;
    done     = 1'b0;
    ext_data = 1'b0;
    alu_mode = 1'b0;

    case (state_q)
      T0: begin
        state_d = T1;
      end
      T1: begin
        case (opcode)
          OP_LOAD: begin
            ext_data = 1'b1;
            rin      = rx_sel;
            done     = 1'b1;
          end
          OP_MOV: begin
            rout = ry_sel;
            rin  = rx_sel;
            done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout     = rx_sel;
            a_in     = 1'b1;
            alu_mode = opcode[0];
            state_d  = T2;
          end
          default: begin
            done = 1'b1;
          end
        endcase
      end
      T2: begin
        // Only reachable for add/sub; anything else drives nothing.
        if (is_alu_op) begin
          rout     = ry_sel;
          g_in     = 1'b1;
          alu_mode = opcode[0];
          state_d  = T3;
        end
      end
      T3: begin
        if (is_alu_op) begin
          g_out    = 1'b1;
          rin      = rx_sel;
          done     = 1'b1;
          alu_mode = opcode[0];
        end
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

  assign bus.Rin           = rin;
  assign bus.Rout          = rout;
  assign bus.ALU_a_in      = a_in;
  assign bus.ALU_g_in      = g_in;
  assign bus.ALU_g_out     = g_out;
  assign bus.Done          = done;
  assign bus.External_data = ext_data;
  assign bus.ALU_mode      = alu_mode;

`ifdef CONTROL_STATE_DEBUG_EN
  assign state_dbg = state_q;
  assign ir_dbg    = ir_q;
`endif

endmodule

// File: tb/tb_control_circuit.sv
// ---------------------------------------------------------------------------
// tb_control_circuit
//   Self-checking bench for control_circuit. Each issued instruction pushes
//   its per-cycle expected strobe vectors (T0 first) into exp_q; the vectors
//   are popped and compared against the DUT on the falling edge of each cycle.
//   Strobe vector packing: {Rin, Rout, ALU_a_in, ALU_g_in, ALU_g_out, Done,
//   External_data, ALU_mode}.
// ---------------------------------------------------------------------------
module tb_control_circuit;

  localparam int W = 14;

  logic clk = 1'b0;
  logic reset;

  control_circuit_if bus ();

`ifdef CONTROL_STATE_DEBUG_EN
  logic [1:0]  state_dbg;
  logic [10:0] ir_dbg;
`endif

  control_circuit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave)
`ifdef CONTROL_STATE_DEBUG_EN
    ,
    .state_dbg (state_dbg),
    .ir_dbg    (ir_dbg)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic logic [W-1:0] pack(input logic [3:0] rin,
                                        input logic [3:0] rout,
                                        input logic a, input logic gi,
                                        input logic go, input logic dn,
                                        input logic ext, input logic md);
    return {rin, rout, a, gi, go, dn, ext, md};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.Rin, bus.Rout, bus.ALU_a_in, bus.ALU_g_in, bus.ALU_g_out,
            bus.Done, bus.External_data, bus.ALU_mode};
  endfunction

  // Register field to one-hot: r1..r4 for codes 1..4, nothing otherwise.
  function automatic logic [3:0] onehot(input logic [2:0] f);
    logic [3:0] r;
    r = 4'b0000;
    if (f >= 3'd1 && f <= 3'd4) r = 4'b0001 << (int'(f) - 1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected behaviour of one instruction, cycle by cycle from T0.
  task automatic push_expected(input logic [10:0] instr);
    logic [2:0] op;
    logic [3:0] dx, dy;
    logic       m;
    op = instr[10:8];
    dx = onehot(instr[7:5]);
    dy = onehot(instr[4:2]);
    m  = (op == 3'b011);
    exp_q.push_back('0);
    case (op)
      3'b000: exp_q.push_back(pack(dx, 4'b0, 0, 0, 0, 1, 1, 0));
      3'b001: exp_q.push_back(pack(dx, dy, 0, 0, 0, 1, 0, 0));
      3'b010, 3'b011: begin
        exp_q.push_back(pack(4'b0, dx, 1, 0, 0, 0, 0, m));
        exp_q.push_back(pack(4'b0, dy, 0, 1, 0, 0, 0, m));
        exp_q.push_back(pack(dx, 4'b0, 0, 0, 1, 1, 0, m));
      end
      default: exp_q.push_back(pack(4'b0, 4'b0, 0, 0, 0, 1, 0, 0));
    endcase
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge while the DUT is in T0; returns on the falling
  // edge of the following T0. With scramble set, INSTRUCTION is replaced by
  // noise from T1 onwards.
  task automatic issue(input string tag, input logic [10:0] instr,
                       input bit scramble);
    int n;
    bus.INSTRUCTION = instr;
    push_expected(instr);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", tag, i), observed(), exp_q.pop_front());
      if (scramble && i >= 1) bus.INSTRUCTION = 11'($urandom_range(0, 2047));
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] ins;
    reset = 1'b0;
    bus.INSTRUCTION = 11'b010_001_010_00;
    repeat (2) begin
      @(negedge clk);
      check("reset_out", observed(), '0);
`ifdef CONTROL_STATE_DEBUG_EN
      check("reset_dbg", W'({state_dbg, ir_dbg}), '0);
`endif
    end
    reset = 1'b1;

    issue("load_r1",  11'b000_001_00110, 1'b0);
    issue("mov_r1r2", 11'b001_001_010_00, 1'b0);
    issue("add_r3r4", 11'b010_011_100_00, 1'b0);
    issue("sub_r2r4", 11'b011_010_100_00, 1'b1);
    issue("nop_101",  11'b101_110_011_01, 1'b0);
    issue("mov_r3r3", 11'b001_011_011_00, 1'b0);
    issue("load_r0",  11'b000_000_11111, 1'b0);
    issue("add_r4r5", 11'b010_100_101_00, 1'b0);

    // Reset asserted in the middle of T2 of an add.
    bus.INSTRUCTION = 11'b010_011_100_00;
    check("abort_t0", observed(), '0);
    @(negedge clk);
    check("abort_t1", observed(), pack(4'b0, 4'b0100, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("abort_t2", observed(), pack(4'b0, 4'b1000, 0, 1, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1 check("abort_async", observed(), '0);
    @(negedge clk);
    check("abort_held", observed(), '0);
    reset = 1'b1;
    issue("after_rst", 11'b000_100_01010, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ins = 11'($urandom_range(0, 2047));
      issue($sformatf("rnd%0d", k), ins, ($urandom_range(0, 1) == 1));
    end

    check("final_idle", observed(), '0);
    check("queue_empty", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
